divu_seq: RTL
=============

Name: divu_seq

Overview:
Multi-cycle unsigned 32/32 divider for the CPU's DIVU path. It is the inverse companion of the combinational unsigned multiplier: it produces quotient (LO) and remainder (HI) by radix-2 restoring division, one bit per clock. A start/busy/done handshake lets the control unit stall the pipeline while a division is in flight.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits. Only 32 is verified.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset; clears all state immediately
start  input  1  request a division; sampled only when the block is not busy
dividend  input  WIDTH  unsigned dividend; captured on the accepting edge
divisor  input  WIDTH  unsigned divisor; captured on the accepting edge
q  output  WIDTH  quotient (to LO); valid when done=1 and held until the next accept
r  output  WIDTH  remainder (to HI); valid when done=1 and held until the next accept
busy  output  1  high while the iterations run
done  output  1  one-cycle pulse when q and r become valid
div_zero  output  1  the captured divisor was 0; valid with done and held with q/r

Behaviour:
- Reset values: q=0, r=0, busy=0, done=0, div_zero=0, FSM in IDLE, iteration counter 0. Reset takes effect immediately without waiting for a clock edge.
- FSM states:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: single cycle with done=1.
- Accept rule: on a rising edge with start=1 and state IDLE or DONE, the block:
  - captures dividend into the quotient/shift register;
  - captures divisor;
  - clears the partial remainder (WIDTH+1 bits);
  - sets the counter to 0 and enters RUN;
  - sets busy=1 and done=0.
- start in RUN is ignored. It is not queued, and the captured operands are not disturbed.
- Each RUN edge performs one step:
  1. Shift {rem, quo} left by 1.
  2. Compute trial = rem - {1'b0, divisor}.
  3. If trial is non-negative, rem=trial and quo[0]=1; otherwise rem is unchanged and quo[0]=0.
  4. Increment the counter.
- On the edge that completes step WIDTH (counter = WIDTH-1):
  - q and r load the final quo and rem[WIDTH-1:0];
  - busy goes to 0, done goes to 1, state goes to DONE.
- Latency: if the accept happens at edge E0, the iterations happen at E1..E32 and done is high for the cycle following E32 (33 edges after accept). busy is high from E0 to E32.
- DONE lasts exactly one cycle, then the block returns to IDLE unless start=1 causes a back-to-back accept. q and r hold their values in IDLE.
- q and r change only on the completion edge or on reset. They do not show intermediate values during RUN; they keep the previous result.
- Divide by zero:
  - there is no special fast path and latency is unchanged;
  - the algorithm naturally yields q=all ones and r=dividend, and these values are required;
  - div_zero=1 is registered on the completion edge and held with q/r;
  - div_zero is cleared to 0 on the next completion edge that has a non-zero divisor.
- Width rules:
  - all arithmetic is unsigned;
  - the partial remainder is WIDTH+1 bits so the subtract borrow is the sign bit;
  - no overflow is possible, and q < 2^WIDTH always.
- Reset mid-operation (asynchronous) aborts the division. All outputs return to their reset values and the next start is accepted normally.
- Operand inputs may change freely after the accept edge without affecting the result.

Test Plan:
- Basic: reset, then dividend=100, divisor=7, start for one cycle. Require busy for 32 cycles, done pulse exactly 33 edges after accept, q=14, r=2, div_zero=0, and q/r held 5 cycles later.
- Extremes: 0xFFFFFFFF/1 gives q=0xFFFFFFFF, r=0. 0xFFFFFFFF/0xFFFFFFFF gives q=1, r=0. 5/9 gives q=0, r=5. 0/3 gives q=0, r=0.
- Divide by zero: 0x12345678/0 gives, after the normal 33-edge latency, q=0xFFFFFFFF, r=0x12345678, div_zero=1. A following 10/3 gives q=3, r=1, div_zero=0.
- Busy protection: accept 1000/10, then at edge 5 apply start with 7/7 and change the operand inputs. Require the result q=100, r=0, and exactly one done pulse.
- Back-to-back: hold start=1 with 50/6 during the done cycle of a prior 9/2 operation. Require q=4, r=1 at the first done, a new accept on the same edge, and q=8, r=2 33 edges later.
- Async reset: assert reset mid-cycle at the 10th RUN cycle. Require busy, done, q and r to go to 0 immediately. Release reset, then run 77/8 and require q=9, r=5.

Source files
------------

// File: rtl/divu_seq.sv
// Sequential unsigned divider: radix-2 restoring division, one quotient bit per clock.
// Produces quotient (LO) and remainder (HI) with a start/busy/done handshake.
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             accept;
  logic             last;

  // One restoring step: the borrow out of the WIDTH+1 bit subtract is trial's MSB.
  always_comb begin
    rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs};
    rem_nxt = rem_sh;
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nxt    = trial;
      quo_nxt[0] = 1'b1;
    end
  end

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      cnt   <= '0;
      rem   <= '0;
      quo   <= dividend;
      dvs   <= divisor;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            // q/r and div_zero only move here, so they hold the previous result during RUN.
            q        <= quo_nxt;
            r        <= rem_nxt[WIDTH-1:0];
            div_zero <= (dvs == '0);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
